// File: rtl/siggen_pkg.sv
// Shared types and width defaults for the sine-generator sweep sequencer.
package siggen_pkg;

  localparam int SWEEP_ADDR_W  = 8;
  localparam int SWEEP_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  typedef struct packed {
    logic [SWEEP_ADDR_W-1:0]  start;
    logic [SWEEP_ADDR_W-1:0]  stop;
    logic [SWEEP_ADDR_W-1:0]  step;
    logic [SWEEP_DWELL_W-1:0] dwell;
    logic [SWEEP_ADDR_W-1:0]  offset;
  } sweep_cfg_t;

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Dwell down-counter: load sets the count, hold freezes it, expire flags a zero count.
module dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!hold && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency sweep sequencer driving the sine generator's en/incr/offset.
// Define SWEEP_CTRL_PINGPONG_EN to bounce between start and stop until aborted.
module sweep_ctrl
  import siggen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = SWEEP_ADDR_W,
  parameter int DWELL_WIDTH   = SWEEP_DWELL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ADDRESS_WIDTH-1:0] cfg_start,
  input  logic [ADDRESS_WIDTH-1:0] cfg_stop,
  input  logic [ADDRESS_WIDTH-1:0] cfg_step,
  input  logic [DWELL_WIDTH-1:0]   cfg_dwell,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
  input  logic                     pause,
  input  logic                     abort,
  output logic                     gen_en,
  output logic [ADDRESS_WIDTH-1:0] gen_incr,
  output logic [ADDRESS_WIDTH-1:0] gen_offset,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = ADDRESS_WIDTH;

  typedef struct packed {
    logic [AW-1:0]          stop;
    logic [AW-1:0]          step;
    logic [DWELL_WIDTH-1:0] dwell_m1;
    logic                   down;
  } run_cfg_t;

  sweep_state_t     state_q, state_d;
  run_cfg_t         cfg_q, cfg_d;
  logic [AW-1:0]    incr_q, incr_d;
  logic [AW-1:0]    offset_q, offset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SWEEP_CTRL_PINGPONG_EN
  logic [AW-1:0]    origin_q, origin_d;
`endif

  logic                   timer_load;
  logic                   timer_hold;
  logic                   timer_expire;
  logic [DWELL_WIDTH-1:0] timer_val;
  logic [DWELL_WIDTH-1:0] accept_dwell_m1;
  logic [AW-1:0]          next_incr;

  // Step one delta toward tgt in AW+1 bits so the clamp sees carries/borrows before truncation.
  function automatic logic [AW-1:0] step_toward(input logic [AW-1:0] cur,
                                                input logic [AW-1:0] tgt,
                                                input logic [AW-1:0] stp,
                                                input logic          dn);
    logic [AW:0] nxt;
    if (dn) begin
      nxt = {1'b0, cur} - {1'b0, stp};
      step_toward = (nxt[AW] || (nxt[AW-1:0] < tgt)) ? tgt : nxt[AW-1:0];
    end else begin
      nxt = {1'b0, cur} + {1'b0, stp};
      step_toward = (nxt > {1'b0, tgt}) ? tgt : nxt[AW-1:0];
    end
  endfunction

  assign accept_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
  assign next_incr       = step_toward(incr_q, cfg_q.stop, cfg_q.step, cfg_q.down);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    incr_d     = incr_q;
    offset_d   = offset_q;
    timer_load = 1'b0;
    timer_hold = 1'b1;
    timer_val  = cfg_q.dwell_m1;
`ifdef SWEEP_CTRL_PINGPONG_EN
    origin_d   = origin_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          state_d        = RUN;
          cfg_d.stop     = cfg_stop;
          cfg_d.step     = cfg_step;
          cfg_d.dwell_m1 = accept_dwell_m1;
          cfg_d.down     = (cfg_stop < cfg_start);
          incr_d         = cfg_start;
          offset_d       = cfg_offset;
          timer_load     = 1'b1;
          timer_val      = accept_dwell_m1;
`ifdef SWEEP_CTRL_PINGPONG_EN
          origin_d       = cfg_start;
`endif
        end
      end

      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (!pause) begin
          timer_hold = 1'b0;
          if (timer_expire) begin
`ifdef SWEEP_CTRL_PINGPONG_EN
            if (incr_q == cfg_q.stop) begin
              // Turn around: the old origin becomes the new target.
              cfg_d.stop = origin_q;
              cfg_d.down = ~cfg_q.down;
              origin_d   = cfg_q.stop;
              incr_d     = step_toward(incr_q, origin_q, cfg_q.step, ~cfg_q.down);
            end else begin
              incr_d = next_incr;
            end
            timer_load = 1'b1;
`else
            if ((incr_q == cfg_q.stop) || (cfg_q.step == '0)) begin
              state_d = DONE;
            end else begin
              incr_d     = next_incr;
              timer_load = 1'b1;
            end
`endif
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_q == RUN) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      incr_q   <= '0;
      offset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SWEEP_CTRL_PINGPONG_EN
      origin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      incr_q   <= incr_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SWEEP_CTRL_PINGPONG_EN
      origin_q <= origin_d;
`endif
    end
  end

  dwell_timer #(
    .WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .hold     (timer_hold),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // Pause gates the generator in the same cycle it freezes the counter.
  assign gen_en     = busy_q & ~pause;
  assign gen_incr   = incr_q;
  assign gen_offset = offset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a driver predicts per-cycle outputs from a value-list model, a monitor compares.
module tb_sweep_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef SWEEP_CTRL_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, cfg_offset = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          pause = 1'b0, abort = 1'b0;
  logic          gen_en, busy, done;
  logic [AW-1:0] gen_incr, gen_offset;

  sweep_ctrl #(.ADDRESS_WIDTH(AW), .DWELL_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_offset(cfg_offset), .pause(pause), .abort(abort),
    .gen_en(gen_en), .gen_incr(gen_incr), .gen_offset(gen_offset),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [AW-1:0] incr;
    logic [AW-1:0] off;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   vals[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt, input int stp);
    if (tgt >= cur) return (cur + stp > tgt) ? tgt : cur + stp;
    return (cur - stp < tgt) ? tgt : cur - stp;
  endfunction

  // Sequence of increment values the sweep visits, one entry per dwell period.
  function automatic void build_vals(input int start, input int stop, input int step);
    int v, tgt, org, t;
    vals.delete();
    v = start;
    vals.push_back(v);
    if (PP) begin
      tgt = stop;
      org = start;
      repeat (80) begin
        if (v == tgt) begin
          t = tgt; tgt = org; org = t;
        end
        v = toward(v, tgt, step);
        vals.push_back(v);
      end
    end else if (step != 0 && start != stop) begin
      while (v != stop) begin
        v = toward(v, stop, step);
        vals.push_back(v);
      end
    end
  endfunction

  task automatic push_exp(input bit en, input int incr, input int off, input bit b, input bit d);
    exp_t e;
    e.en = en; e.incr = AW'(incr); e.off = AW'(off); e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_sweep(input int start, input int stop, input int step, input int dwell,
                           input int offset, input int pause_from, input int pause_len,
                           input int abort_at, input int reset_at, input bit rnd);
    int  idx, rem, cyc, per;
    bit  fin, p, a;
    build_vals(start, stop, step);
    per = (dwell == 0) ? 1 : dwell;

    check("ready_idle", 32'(cfg_ready), 32'(1));
    check("en_idle", 32'(gen_en), 32'(0));
    cfg_start = AW'(start); cfg_stop = AW'(stop); cfg_step = AW'(step);
    cfg_dwell = DW'(dwell); cfg_offset = AW'(offset);
    cfg_valid = 1'b1;
    abort = rnd ? 1'($urandom_range(1)) : 1'b0;   // abort must be ignored while idle
    @(posedge clk); #1;
    cfg_valid = 1'b0; abort = 1'b0;
    cfg_start = AW'($urandom); cfg_stop = AW'($urandom); cfg_step = AW'($urandom);
    cfg_dwell = DW'($urandom); cfg_offset = AW'($urandom);

    idx = 0; rem = per; cyc = 0; fin = 1'b0;
    while (!fin) begin
      if (cyc == reset_at) begin
        rst = 1'b0; #1;
        check("rst_en", 32'(gen_en), 32'(0));
        check("rst_incr", 32'(gen_incr), 32'(0));
        check("rst_offset", 32'(gen_offset), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(1));
        pause = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      p = (cyc >= pause_from && cyc < pause_from + pause_len) ||
          (rnd && $urandom_range(4) == 0);
      a = (cyc == abort_at) || (rnd && $urandom_range(59) == 0) || (PP && cyc >= 40);
      pause = p; abort = a;
      push_exp(!p, vals[idx], offset, 1'b1, 1'b0);
      if (a) begin
        fin = 1'b1;
      end else if (!p) begin
        rem--;
        if (rem == 0) begin
          if (idx == vals.size() - 1) fin = 1'b1;
          else begin idx++; rem = per; end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    pause = rnd ? 1'($urandom_range(1)) : 1'b0;
    abort = rnd ? 1'($urandom_range(1)) : 1'b0;
    push_exp(1'b0, vals[idx], offset, 1'b0, 1'b1);
    @(posedge clk); #1;
    pause = 1'b0; abort = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (busy || done)) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'({busy, done}), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("gen_en", 32'(gen_en), 32'(e.en));
          check("gen_incr", 32'(gen_incr), 32'(e.incr));
          check("gen_offset", 32'(gen_offset), 32'(e.off));
          check("busy", 32'(busy), 32'(e.busy));
          check("done", 32'(done), 32'(e.done));
          check("ready_active", 32'(cfg_ready), 32'(0));
        end
      end
    end
  end

  initial begin : driver
    int s, t, st;
    #2;
    check("reset_en", 32'(gen_en), 32'(0));
    check("reset_incr", 32'(gen_incr), 32'(0));
    check("reset_offset", 32'(gen_offset), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_sweep(4, 16, 4, 3, 7, -1, 0, -1, -1, 1'b0);     // up sweep, exact landing on stop
    run_sweep(20, 5, 6, 2, 33, -1, 0, -1, -1, 1'b0);    // down sweep, clamped final step
    run_sweep(10, 10, 3, 0, 1, -1, 0, -1, -1, 1'b0);    // start==stop, dwell 0
    run_sweep(0, 8, 2, 4, 9, 6, 5, -1, -1, 1'b0);       // five-cycle pause mid-value
    run_sweep(4, 16, 4, 3, 2, -1, 0, 4, -1, 1'b0);      // abort on 2nd cycle of incr 8
    run_sweep(4, 16, 4, 3, 5, -1, 0, -1, 7, 1'b0);      // reset mid-sweep
    run_sweep(250, 255, 3, 1, 0, -1, 0, -1, -1, 1'b0);  // clamp at top, no wrap
    run_sweep(3, 0, 7, 2, 0, -1, 0, -1, -1, 1'b0);      // clamp at bottom, no wrap
    run_sweep(40, 90, 0, 2, 4, -1, 0, -1, -1, 1'b0);    // step 0
    run_sweep(2, 6, 2, 1, 8, -1, 0, 9, -1, 1'b0);       // turn-around case when bouncing

    repeat (30) begin
      s  = $urandom_range(255);
      t  = ($urandom_range(5) == 0) ? s : $urandom_range(255);
      st = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 40);
      run_sweep(s, t, st, $urandom_range(4), $urandom_range(255), -1, 0, -1, -1, 1'b1);
      repeat ($urandom_range(2)) begin
        abort = 1'($urandom_range(1));
        check("ready_gap", 32'(cfg_ready), 32'(1));
        @(posedge clk); #1;
      end
      abort = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
